// File: rtl/motor_ramp_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : motor_ramp_sequencer
// Description : Sequences one DC-motor run: soft-start to a latched target
//               duty, hold for a programmed number of ticks, soft-stop.
//               A fault input aborts to a latched FAULT state.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module motor_ramp_sequencer #(
  parameter int DUTY_W    = 8,
  parameter int DUTY_MAX  = 255,
  parameter int RAMP_STEP = 16,
  parameter int RUN_W     = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              dir_req,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic [RUN_W-1:0]  run_ticks,
  input  logic              fault,
  input  logic              clear_fault,
  output logic [DUTY_W-1:0] duty,
  output logic              motor_en,
  output logic              motor_dir,
  output logic              busy,
  output logic              done,
  output logic              fault_latched,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam logic [DUTY_W-1:0] C_DUTY_MAX = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W:0]   C_STEP     = (DUTY_W+1)'(RAMP_STEP);

  state_t              state_q, state_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic                motor_en_q, motor_en_d;
  logic                motor_dir_q, motor_dir_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fault_latched_q, fault_latched_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic [RUN_W-1:0]    run_len_q, run_len_d;
  logic [RUN_W-1:0]    cnt_q, cnt_d;

  logic [DUTY_W-1:0]   target_clamped;
  logic [DUTY_W:0]     ramp_sum;
  logic [DUTY_W-1:0]   duty_up;
  logic [DUTY_W-1:0]   duty_down;

  // Saturating ramp arithmetic; the up-sum carries one extra bit so it never wraps.
  always_comb begin
    target_clamped = (target_duty > C_DUTY_MAX) ? C_DUTY_MAX : target_duty;
    ramp_sum       = {1'b0, duty_q} + C_STEP;
    duty_up        = (ramp_sum > {1'b0, target_q}) ? target_q : ramp_sum[DUTY_W-1:0];
    duty_down      = ({1'b0, duty_q} > C_STEP) ? (duty_q - C_STEP[DUTY_W-1:0]) : '0;
  end

  // Next-state and output decode; fault overrides every state, stop beats start/tick.
  always_comb begin
    state_d         = state_q;
    duty_d          = duty_q;
    motor_en_d      = motor_en_q;
    motor_dir_d     = motor_dir_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    fault_latched_d = fault_latched_q;
    target_d        = target_q;
    run_len_d       = run_len_q;
    cnt_d           = cnt_q;

    if (fault) begin
      state_d         = ST_FAULT;
      duty_d          = '0;
      motor_en_d      = 1'b0;
      busy_d          = 1'b0;
      fault_latched_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop && (target_clamped != '0)) begin
            state_d     = ST_RAMP_UP;
            target_d    = target_clamped;
            run_len_d   = run_ticks;
            motor_dir_d = dir_req;
            duty_d      = '0;
            motor_en_d  = 1'b1;
            busy_d      = 1'b1;
          end
        end
        ST_RAMP_UP: begin
          if (stop) begin
            state_d = ST_RAMP_DOWN;
          end else if (duty_q == target_q) begin
            state_d = ST_RUN;
            cnt_d   = run_len_q;
          end else if (tick) begin
            duty_d = duty_up;
          end
        end
        ST_RUN: begin
          if (stop || (cnt_q == '0)) begin
            state_d = ST_RAMP_DOWN;
          end else if (tick) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RAMP_DOWN: begin
          if (duty_q == '0) begin
            state_d    = ST_IDLE;
            motor_en_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else if (tick) begin
            duty_d = duty_down;
          end
        end
        ST_FAULT: begin
          if (clear_fault) begin
            state_d         = ST_IDLE;
            fault_latched_d = 1'b0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          duty_d     = '0;
          motor_en_d = 1'b0;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      duty_q          <= '0;
      motor_en_q      <= 1'b0;
      motor_dir_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fault_latched_q <= 1'b0;
      target_q        <= '0;
      run_len_q       <= '0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      duty_q          <= duty_d;
      motor_en_q      <= motor_en_d;
      motor_dir_q     <= motor_dir_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      fault_latched_q <= fault_latched_d;
      target_q        <= target_d;
      run_len_q       <= run_len_d;
      cnt_q           <= cnt_d;
    end
  end

  assign duty          = duty_q;
  assign motor_en      = motor_en_q;
  assign motor_dir     = motor_dir_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault_latched = fault_latched_q;
  assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_motor_ramp_sequencer
// Description : Directed self-checking bench for motor_ramp_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_motor_ramp_sequencer;

  logic        clk_in = 1'b0;
  logic        rst, tick, start, stop, dir_req, fault, clear_fault;
  logic [7:0]  target_duty;
  logic [15:0] run_ticks;
  logic [7:0]  duty;
  logic        motor_en, motor_dir, busy, done, fault_latched;
  logic [2:0]  state;

  motor_ramp_sequencer #(
    .DUTY_W(8), .DUTY_MAX(200), .RAMP_STEP(16), .RUN_W(16)
  ) u_dut (
    .clk_in(clk_in), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .dir_req(dir_req), .target_duty(target_duty), .run_ticks(run_ticks),
    .fault(fault), .clear_fault(clear_fault), .duty(duty), .motor_en(motor_en),
    .motor_dir(motor_dir), .busy(busy), .done(done),
    .fault_latched(fault_latched), .state(state)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int tcnt, last_duty, done_cnt, done_bad, run_cyc, run_tk, max_duty;
  bit tick_en;
  int dq[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample just after the edge, log activity, drive next tick.
  task automatic step();
    @(posedge clk_in);
    #1;
    if (int'(duty) != last_duty) begin
      dq.push_back(int'(duty));
      last_duty = int'(duty);
    end
    if (done) begin
      done_cnt++;
      if (state != 3'd0 || motor_en || busy) done_bad++;
    end
    if (state == 3'd2) run_cyc++;
    if (int'(duty) > max_duty) max_duty = int'(duty);
    tcnt++;
    tick = tick_en && (tcnt % 4 == 0);
    if (state == 3'd2 && tick) run_tk++;
  endtask

  task automatic clear_log();
    dq.delete();
    last_duty = int'(duty);
    done_cnt = 0; done_bad = 0; run_cyc = 0; run_tk = 0; max_duty = 0;
  endtask

  // Issue a start, then scramble the latched inputs to prove they are ignored.
  task automatic launch(input int tgt, input int rt, input bit dir);
    clear_log();
    target_duty = 8'(tgt);
    run_ticks   = 16'(rt);
    dir_req     = dir;
    tick_en     = 1'b0;
    tick        = 1'b0;
    start       = 1'b1;
    step();
    start       = 1'b0;
    target_duty = 8'hFF;
    run_ticks   = 16'hFFFF;
    tick_en     = 1'b1;
    tcnt        = 0;
    tick        = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, int'(done_cnt > 0), 1);
    for (int i = 0; i < 3; i++) step();
    tick_en = 1'b0;
    tick    = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int exp[$]);
    check({tag, "_len"}, dq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dq.size(); i++)
      check($sformatf("%s_duty%0d", tag, i), dq[i], exp[i]);
  endtask

  initial begin
    int n;
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; dir_req = 1'b0;
    fault = 1'b0; clear_fault = 1'b0; target_duty = '0; run_ticks = '0;
    tick_en = 1'b0; tcnt = 0;
    step(); step();
    check("rst_state", state, 0);
    check("rst_duty", duty, 0);
    check("rst_en", motor_en, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault_latched, 0);
    rst = 1'b0;
    step();

    // 1: nominal run
    launch(48, 3, 1'b1);
    check("t1_busy", busy, 1);
    check("t1_en", motor_en, 1);
    check("t1_duty0", duty, 0);
    wait_done("t1", 300);
    check_seq("t1", '{16, 32, 48, 32, 16, 0});
    check("t1_run_ticks", run_tk, 3);
    check("t1_run_cycles", run_cyc, 12);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_bad", done_bad, 0);
    check("t1_dir_hold", motor_dir, 1);

    // 2: saturated ramp
    launch(40, 1, 1'b0);
    wait_done("t2", 300);
    check_seq("t2", '{16, 32, 40, 24, 8, 0});
    check("t2_max", max_duty, 40);
    check("t2_dir", motor_dir, 0);

    // 3: clamp to DUTY_MAX, zero-length run
    launch(250, 0, 1'b1);
    wait_done("t3", 600);
    check("t3_max", max_duty, 200);
    check("t3_run_cycles", run_cyc, 1);
    check("t3_len", dq.size(), 26);
    if (dq.size() == 26) begin
      check("t3_plateau", dq[12], 200);
      check("t3_first_down", dq[13], 184);
      check("t3_last", dq[25], 0);
    end
    clear_log();
    target_duty = 8'd0; start = 1'b1;
    step(); step();
    check("t3_zero_busy", busy, 0);
    check("t3_zero_state", state, 0);
    start = 1'b0;

    // 4: early stop on the second RUN tick
    launch(48, 5, 1'b1);
    n = 0;
    while (!(state == 3'd2 && run_tk == 2) && n < 300) begin step(); n++; end
    check("t4_reach_run", int'(state == 3'd2 && run_tk == 2), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4_state_down", state, 3);
    check("t4_duty_hold", duty, 48);
    wait_done("t4", 300);
    check_seq("t4", '{16, 32, 48, 32, 16, 0});
    check("t4_done_cnt", done_cnt, 1);
    clear_log();
    target_duty = 8'd48; start = 1'b1; stop = 1'b1;
    step(); step();
    check("t4_ss_state", state, 0);
    check("t4_ss_busy", busy, 0);
    start = 1'b0; stop = 1'b0;

    // 5: fault during ramp-up
    launch(48, 3, 1'b0);
    n = 0;
    while (duty != 8'd32 && n < 300) begin step(); n++; end
    check("t5_reach32", duty, 32);
    fault = 1'b1;
    step();
    check("t5_duty", duty, 0);
    check("t5_en", motor_en, 0);
    check("t5_latched", fault_latched, 1);
    check("t5_state", state, 4);
    check("t5_busy", busy, 0);
    clear_fault = 1'b1;
    step();
    check("t5_clear_blocked", state, 4);
    fault = 1'b0; clear_fault = 1'b0; start = 1'b1; target_duty = 8'd48;
    step();
    check("t5_start_ignored", state, 4);
    check("t5_start_busy", busy, 0);
    start = 1'b0; clear_fault = 1'b1;
    step();
    check("t5_cleared_state", state, 0);
    check("t5_cleared_flag", fault_latched, 0);
    clear_fault = 1'b0;
    step();
    check("t5_no_done", done_cnt, 0);
    tick_en = 1'b0; tick = 1'b0;

    // 6: reset mid-RUN with a tick pending, direction change ignored
    launch(48, 5, 1'b1);
    dir_req = 1'b0;
    n = 0;
    while (!(state == 3'd2 && tick) && n < 300) begin step(); n++; end
    check("t6_reach_run", int'(state == 3'd2 && tick), 1);
    check("t6_dir_held", motor_dir, 1);
    rst = 1'b1;
    step();
    check("t6_state", state, 0);
    check("t6_duty", duty, 0);
    check("t6_en", motor_en, 0);
    check("t6_dir", motor_dir, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_fault", fault_latched, 0);
    rst = 1'b0; tick_en = 1'b0; tick = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
